fpcvt_arbiter: RTL and testbench

Shares one combinational FPCVT converter (13-bit two's-complement D to sign S, 3-bit exponent E, 5-bit mantissa F) among NREQ requesters. Requests are accepted with a per-requester valid/ready handshake and granted round-robin. Each accepted operand is converted and returned on a single registered output port tagged with the requester index. The block sits between the input-capture logic and the display/result path.

---
 rtl/fpcvt_arbiter_if.sv | 28 ++
 rtl/fpcvt_arbiter.sv | 157 +++++++++++++++
 tb/tb_fpcvt_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fpcvt_arbiter_if.sv
// fpcvt_arbiter_if: request/result bundle for the shared FPCVT arbiter.
// slave = arbiter side, master = requesters + result consumer side.
interface fpcvt_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [13*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_S;
    logic [2:0]           out_E;
    logic [4:0]           out_F;
    logic [ID_W-1:0]      out_id;
    logic                 busy;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_S, out_E, out_F, out_id, busy
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_S, out_E, out_F, out_id, busy
    );
endinterface

// File: rtl/fpcvt_arbiter.sv
// fpcvt_arbiter: one combinational FPCVT (13-bit two's complement -> S/E/F)
// shared round-robin among NREQ requesters, result on a registered port.
// Optional macro FPCVT_ARB_STATS_EN adds a saturating 16-bit count of
// retired results on port conv_count.
module fpcvt_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fpcvt_arbiter_if.slave       bus
`ifdef FPCVT_ARB_STATS_EN
    ,
    output logic [15:0]          conv_count
`endif
);
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t          r_state, w_next;
    logic [ID_W-1:0] r_ptr, r_id, w_g;
    logic [12:0]     r_op;
    logic [ID_W:0]   w_idx;
    logic            w_found, w_grant_en, w_accept;

    logic            r_out_valid, r_S;
    logic [2:0]      r_E;
    logic [4:0]      r_F;
    logic [ID_W-1:0] r_out_id;

    logic            w_S, w_r;
    logic [12:0]     w_M;
    logic [2:0]      w_e0, w_E;
    logic [4:0]      w_f0, w_F;

    // Round-robin search starting at r_ptr; scanning downward so the last hit
    // (smallest offset from r_ptr) wins.
    always_comb begin
        w_found = 1'b0;
        w_g     = '0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (ID_W + 1)'(k);
            if (w_idx >= (ID_W + 1)'(NREQ))
                w_idx = w_idx - (ID_W + 1)'(NREQ);
            if (bus.req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_g     = w_idx[ID_W-1:0];
            end
        end
    end

    // Grants only open in IDLE, or in OUT on the cycle the result retires.
    assign w_grant_en = !rst && ((r_state == IDLE) || (r_state == OUT && bus.out_ready));
    assign w_accept   = w_grant_en && w_found;

    // One-hot ready for the selected requester.
    always_comb begin
        bus.req_ready = '0;
        if (w_accept)
            bus.req_ready[w_g] = 1'b1;
    end

    // FPCVT: magnitude, exponent from leading one, 5-bit window, round-half-up
    // with exponent carry and clamp at the top code.
    always_comb begin
        w_S  = r_op[12];
        w_M  = w_S ? (~r_op + 13'd1) : r_op;
        if      (w_M[11]) w_e0 = 3'd7;
        else if (w_M[10]) w_e0 = 3'd6;
        else if (w_M[9])  w_e0 = 3'd5;
        else if (w_M[8])  w_e0 = 3'd4;
        else if (w_M[7])  w_e0 = 3'd3;
        else if (w_M[6])  w_e0 = 3'd2;
        else if (w_M[5])  w_e0 = 3'd1;
        else              w_e0 = 3'd0;
        w_f0 = 5'(w_M >> w_e0);
        w_r  = (w_e0 != 3'd0) && w_M[w_e0 - 3'd1];
        w_E  = w_e0;
        w_F  = w_f0;
        if (w_M[12]) begin
            // Only -4096 reaches bit 12; it saturates to the largest code.
            w_E = 3'd7;
            w_F = 5'b11111;
        end else if (w_r) begin
            if (w_f0 != 5'b11111) begin
                w_F = w_f0 + 5'd1;
            end else if (w_e0 != 3'd7) begin
                w_E = w_e0 + 3'd1;
                w_F = 5'b10000;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CONV;
            CONV:    w_next = OUT;
            OUT:     if (bus.out_ready) w_next = w_accept ? CONV : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, pointer advance and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_id        <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_S         <= 1'b0;
            r_E         <= '0;
            r_F         <= '0;
            r_out_id    <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.req_data[13*w_g +: 13];
                r_id  <= w_g;
                r_ptr <= (w_g == ID_W'(NREQ - 1)) ? '0 : w_g + ID_W'(1);
            end
            if (r_state == CONV) begin
                r_S         <= w_S;
                r_E         <= w_E;
                r_F         <= w_F;
                r_out_id    <= r_id;
                r_out_valid <= 1'b1;
            end else if (r_state == OUT && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_S     = r_S;
    assign bus.out_E     = r_E;
    assign bus.out_F     = r_F;
    assign bus.out_id    = r_out_id;
    assign bus.busy      = (r_state != IDLE);

`ifdef FPCVT_ARB_STATS_EN
    // Saturating count of retired results.
    always_ff @(posedge clk) begin
        if (rst)
            conv_count <= '0;
        else if (r_out_valid && bus.out_ready && conv_count != 16'hFFFF)
            conv_count <= conv_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fpcvt_arbiter.sv
// tb_fpcvt_arbiter: directed checks of conversion, round-robin, backpressure
// and reset for fpcvt_arbiter with NREQ=4.
module tb_fpcvt_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] snap;

    fpcvt_arbiter_if #(.NREQ(4)) bus ();

`ifdef FPCVT_ARB_STATS_EN
    logic [15:0] conv_count;
    fpcvt_arbiter #(.NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus), .conv_count(conv_count));
`else
    fpcvt_arbiter #(.NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [12:0] d);
        bus.req_data[13*i +: 13] = d;
    endtask

    // One isolated request through CONV and OUT with out_ready high.
    task automatic do_conv(input string tag, input int idx, input logic [12:0] d,
                           input logic eS, input logic [2:0] eE, input logic [4:0] eF);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        bus.req_valid = '0;
        bus.req_valid[idx] = 1'b1;
        set_req(idx, d);
        bus.out_ready = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(oh));
        tick();
        bus.req_valid = '0;
        chk({tag, ".conv_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".conv_nv"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".conv_noready"}, 32'(bus.req_ready), 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".S"}, 32'(bus.out_S), 32'(eS));
        chk({tag, ".E"}, 32'(bus.out_E), 32'(eE));
        chk({tag, ".F"}, 32'(bus.out_F), 32'(eF));
        chk({tag, ".id"}, 32'(bus.out_id), 32'(idx));
        tick();
        chk({tag, ".retired"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        // Reset state, with requests present: no ready while rst is high.
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.S", 32'(bus.out_S), 32'd0);
        chk("rst.E", 32'(bus.out_E), 32'd0);
        chk("rst.F", 32'(bus.out_F), 32'd0);
        chk("rst.id", 32'(bus.out_id), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
`ifdef FPCVT_ARB_STATS_EN
        chk("rst.count", 32'(conv_count), 32'd0);
`endif
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // Conversion vectors (expected values worked from the conversion rules).
        do_conv("v5",     0, 13'd5,    1'b0, 3'd0, 5'b00101);
        do_conv("vm1",    1, 13'h1FFF, 1'b1, 3'd0, 5'b00001);
        do_conv("v63",    2, 13'd63,   1'b0, 3'd2, 5'b10000);
        do_conv("v50",    3, 13'd50,   1'b0, 3'd1, 5'b11001);
        do_conv("v4095",  0, 13'd4095, 1'b0, 3'd7, 5'b11111);
        do_conv("vm4096", 1, 13'h1000, 1'b1, 3'd7, 5'b11111);
        // 2047: E=6 window 11111 rounds up, exponent carries to 7 with F=10000.
        do_conv("v2047",  2, 13'd2047, 1'b0, 3'd7, 5'b10000);
        do_conv("vm63",   3, -13'sd63, 1'b1, 3'd2, 5'b10000);
        do_conv("v200",   0, 13'd200,  1'b0, 3'd3, 5'b11001);
`ifdef FPCVT_ARB_STATS_EN
        chk("count9", 32'(conv_count), 32'd9);
`endif

        // Fairness from a fresh pointer: ids 0,1,2,3,0,1 every 2 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 13'(i + 1));
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        #1;
        chk("rr.first_ready", 32'(bus.req_ready), 32'h1);
        tick();
        for (int j = 0; j < 6; j++) begin
            chk("rr.conv_ready", 32'(bus.req_ready), 32'd0);
            tick();
            chk("rr.valid", 32'(bus.out_valid), 32'd1);
            chk("rr.id", 32'(bus.out_id), 32'(j % 4));
            chk("rr.F", 32'(bus.out_F), 32'((j % 4) + 1));
            chk("rr.next_ready", 32'(bus.req_ready), 32'(4'b0001 << ((j + 1) % 4)));
            tick();
        end

        // Now in CONV holding requester 2; stall the consumer.
        bus.out_ready = 1'b0;
        tick();
        snap = {19'd0, bus.out_S, bus.out_E, bus.out_F, bus.out_id};
        chk("bp.id", 32'(bus.out_id), 32'd2);
        for (int c = 0; c < 5; c++) begin
            chk("bp.valid", 32'(bus.out_valid), 32'd1);
            chk("bp.stable", {19'd0, bus.out_S, bus.out_E, bus.out_F, bus.out_id}, snap);
            chk("bp.ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(bus.req_ready), 32'h8);
        tick();
        chk("bp.retired", 32'(bus.out_valid), 32'd0);
        chk("bp.conv_busy", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b0;
        tick();
        chk("bp.next_id", 32'(bus.out_id), 32'd3);
        chk("bp.next_valid", 32'(bus.out_valid), 32'd1);

        // Reset while a result is held in OUT.
        rst = 1'b1;
        #1;
        chk("mid.rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("mid.valid", 32'(bus.out_valid), 32'd0);
        chk("mid.S", 32'(bus.out_S), 32'd0);
        chk("mid.E", 32'(bus.out_E), 32'd0);
        chk("mid.F", 32'(bus.out_F), 32'd0);
        chk("mid.id", 32'(bus.out_id), 32'd0);
        chk("mid.busy", 32'(bus.busy), 32'd0);
`ifdef FPCVT_ARB_STATS_EN
        chk("mid.count", 32'(conv_count), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("mid.first_ready", 32'(bus.req_ready), 32'h1);
        tick();
        tick();
        chk("mid.first_id", 32'(bus.out_id), 32'd0);
        chk("mid.first_F", 32'(bus.out_F), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
